// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: FIFO-buffered operand driver for a sequential MAC; clears, feeds, drains and captures a dot-product batch.
module mac_operand_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic        drv_clk_i,
  input  logic        drv_reset_i,
  input  logic        start_i,
  input  logic [7:0]  batch_len_i,
  input  logic        push_valid_i,
  input  logic [4:0]  push_multiplicand_i,
  input  logic [4:0]  push_multiplier_i,
  output logic        push_ready_o,
  output logic [4:0]  mac_multiplicand_o,
  output logic [4:0]  mac_multiplier_o,
  output logic        mac_nreset_o,
  input  logic        mac_fetching_i,
  input  logic        mac_updating_i,
  input  logic [15:0] mac_result_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] result_o,
  output logic [7:0]  issued_count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, CAPTURE, DONE} state_t;
  state_t state;
  logic [4:0] mem_a [FIFO_DEPTH];
  logic [4:0] mem_b [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0] len, issued;
  logic [2:0] outstanding, target, out_next;
  logic [CW-1:0] clr_cnt;
  logic upd_q, empty, full, push, present_real, real_fetch, fetch, comp, active;
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push = push_valid_i && !full;
    active = (state == RUN) || (state == DRAIN);
    present_real = (state == RUN) && !empty && (issued < len);
    real_fetch = present_real && mac_fetching_i;
    fetch = active && mac_fetching_i;
    comp = active && mac_updating_i && !upd_q && (outstanding != 3'd0);
    out_next = outstanding + 3'(fetch) - 3'(comp);
    mac_multiplicand_o = present_real ? mem_a[rd_ptr[AW-1:0]] : 5'd0;
    mac_multiplier_o = present_real ? mem_b[rd_ptr[AW-1:0]] : 5'd0;
    push_ready_o = !full;
    busy_o = (state == CLEAR) || active || (state == CAPTURE);
    done_o = state == DONE;
    issued_count_o = issued;
  end
  always_ff @(posedge drv_clk_i)
    if (push) begin
      mem_a[wr_ptr[AW-1:0]] <= push_multiplicand_i;
      mem_b[wr_ptr[AW-1:0]] <= push_multiplier_i;
    end
  always_ff @(posedge drv_clk_i) begin
    if (drv_reset_i) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len <= '0;
      issued <= '0;
      outstanding <= '0;
      target <= '0;
      clr_cnt <= '0;
      mac_nreset_o <= 1'b0;
      result_o <= '0;
      upd_q <= 1'b0;
    end else begin
      upd_q <= mac_updating_i;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (real_fetch) rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE, DONE: begin
          mac_nreset_o <= 1'b1;
          if (start_i) begin
            len <= batch_len_i;
            issued <= '0;
            outstanding <= '0;
            target <= '0;
            result_o <= '0;
            clr_cnt <= '0;
            mac_nreset_o <= 1'b0;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          outstanding <= '0;
          if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
            mac_nreset_o <= 1'b1;
            state <= (len == 8'd0) ? CAPTURE : RUN;
          end else clr_cnt <= clr_cnt + 1'b1;
        end
        RUN: begin
          outstanding <= out_next;
          if (real_fetch) begin
            issued <= issued + 8'd1;
            if (issued + 8'd1 == len) begin
              target <= out_next;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          outstanding <= out_next;
          if (comp) begin
            target <= target - 3'd1;
            if (target == 3'd1) state <= CAPTURE;
          end
        end
        CAPTURE: begin
          result_o <= mac_result_i;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder: directed bench with a simple sequential MAC model driving the feeder.
module tb_mac_operand_feeder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pv = 1'b0;
  logic [7:0] blen = '0;
  logic [4:0] pa = '0, pb = '0;
  logic push_ready, mac_nreset, busy, done;
  logic [4:0] mac_a, mac_b;
  logic [15:0] result;
  logic [7:0] issued;
  logic mac_fetching, mac_updating;
  logic [1:0] phase = '0;
  logic [15:0] acc = '0;
  logic [9:0] prod = '0;
  int checks = 0, errors = 0, cyc = 0, last_comp = 0, zero_fills = 0;
  logic upd_prev = 1'b0;
  mac_operand_feeder dut (
    .drv_clk_i(clk), .drv_reset_i(rst), .start_i(start), .batch_len_i(blen),
    .push_valid_i(pv), .push_multiplicand_i(pa), .push_multiplier_i(pb),
    .push_ready_o(push_ready), .mac_multiplicand_o(mac_a), .mac_multiplier_o(mac_b),
    .mac_nreset_o(mac_nreset), .mac_fetching_i(mac_fetching), .mac_updating_i(mac_updating),
    .mac_result_i(acc), .busy_o(busy), .done_o(done), .result_o(result),
    .issued_count_o(issued)
  );
  always #5 clk = ~clk;
  assign mac_fetching = mac_nreset && phase == 2'd0;
  assign mac_updating = mac_nreset && phase == 2'd3;
  always @(posedge clk) begin
    if (!mac_nreset) begin
      phase <= '0;
      acc <= '0;
      prod <= '0;
    end else begin
      phase <= phase + 2'd1;
      if (phase == 2'd0) prod <= 10'(mac_a) * 10'(mac_b);
      if (phase == 2'd3) acc <= acc + 16'(prod);
    end
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    upd_prev <= mac_updating;
    if (mac_updating && !upd_prev && busy) last_comp <= cyc + 1;
    if (mac_fetching && busy && mac_a == 5'd0 && mac_b == 5'd0) zero_fills <= zero_fills + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    pv = 1'b1;
    pa = a;
    pb = b;
    @(negedge clk);
    pv = 1'b0;
  endtask
  task automatic go(input logic [7:0] l);
    @(negedge clk);
    start = 1'b1;
    blen = l;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 1);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(push_ready), 1);
    chk("rst_mac_a", 32'(mac_a), 0);
    chk("rst_mac_b", 32'(mac_b), 0);
    chk("rst_nreset", 32'(mac_nreset), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_issued", 32'(issued), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("nreset_rise", 32'(mac_nreset), 1);
    push(5'd3, 5'd4);
    go(8'd1);
    chk("single_busy", 32'(busy), 1);
    wait_done("single_done");
    chk("single_result", 32'(result), 12);
    chk("single_issued", 32'(issued), 1);
    chk("single_ready", 32'(push_ready), 1);
    chk("single_mac_a_idle", 32'(mac_a), 0);
    repeat (6) @(negedge clk);
    chk("single_hold", 32'(result), 12);
    for (int i = 0; i < 4; i++) push(5'd31, 5'd31);
    chk("max_full", 32'(push_ready), 0);
    go(8'd4);
    n = 0;
    while (!push_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("max_ready_recover", 32'(push_ready), 1);
    chk("max_issued_at_recover", 32'(issued), 1);
    wait_done("max_done");
    chk("max_result", 32'(result), 3844);
    chk("max_issued", 32'(issued), 4);
    go(8'd3);
    repeat (12) @(negedge clk);
    push(5'd2, 5'd5);
    repeat (12) @(negedge clk);
    push(5'd7, 5'd1);
    repeat (12) @(negedge clk);
    push(5'd6, 5'd6);
    wait_done("starve_done");
    chk("starve_result", 32'(result), 53);
    chk("starve_zero_fills", 32'(zero_fills > 0), 1);
    chk("starve_done_timing", 32'(cyc), 32'(last_comp + 1));
    push(5'd5, 5'd5);
    go(8'd0);
    chk("zero_result_cleared", 32'(result), 0);
    n = 0;
    while (!mac_nreset && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("zero_clear_len", 32'(n), 2);
    wait_done("zero_done");
    chk("zero_result", 32'(result), 0);
    chk("zero_issued", 32'(issued), 0);
    go(8'd1);
    wait_done("left_done");
    chk("left_result", 32'(result), 25);
    push(5'd2, 5'd3);
    go(8'd1);
    chk("b2b_result_cleared", 32'(result), 0);
    chk("b2b_done_cleared", 32'(done), 0);
    wait_done("b2b_done");
    chk("b2b_result", 32'(result), 6);
    push(5'd7, 5'd7);
    push(5'd9, 5'd9);
    go(8'd1);
    n = 0;
    while (issued != 8'd1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mid_issued", 32'(issued), 1);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ready", 32'(push_ready), 1);
    chk("mid_mac_a", 32'(mac_a), 0);
    chk("mid_nreset", 32'(mac_nreset), 0);
    chk("mid_busy_rst", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_result", 32'(result), 0);
    chk("mid_issued_rst", 32'(issued), 0);
    rst = 1'b0;
    push(5'd1, 5'd1);
    go(8'd1);
    wait_done("post_rst_done");
    chk("post_rst_result", 32'(result), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
